// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port;
// every word is tagged with its source ID so the read side can demultiplex.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                           wclk,
    input  logic                           sync_rstn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_wfull,
    output logic                           fifo_winc,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d, last_q, last_d, pick;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  found, g_valid, g_last, beat, done;
    // First valid requester strictly after the last grant, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = ID_WIDTH'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end
    assign g_valid    = req_valid[grant_q];
    assign g_last     = req_last[grant_q];
    assign busy       = state_q == GRANT;
    assign beat       = busy & g_valid & ~fifo_wfull;
    // A valid dropped during a stall only releases once the FIFO has room again.
    assign done       = (beat & (g_last | ((cnt_q + 1'b1) == CNT_WIDTH'(MAX_BURST))))
                      | (busy & ~g_valid & ~fifo_wfull);
    assign fifo_winc  = beat;
    assign req_ready  = (busy & ~fifo_wfull) ? NUM_REQ'(1) << grant_q : '0;
    assign fifo_wdata = {grant_q, req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH]};
    assign grant_id   = grant_q;
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = beat ? cnt_q + 1'b1 : cnt_q;
        if (state_q == IDLE && found) begin
            state_d = GRANT;
            grant_d = pick;
            cnt_d   = '0;
        end
        if (done) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end
    always_ff @(posedge wclk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: queue-driven requesters, expected FIFO words in a
// scoreboard checked by an independent monitor, plus directed status checks.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    logic            wclk = 1'b0, sync_rstn = 1'b0, fifo_wfull = 1'b0;
    logic [N-1:0]    req_valid, req_last, req_ready, xfer;
    logic [N*DW-1:0] req_data;
    logic            fifo_winc, busy;
    logic [9:0]      fifo_wdata;
    logic [1:0]      grant_id;
    logic [8:0]      pq [N][$];
    logic [9:0]      exp_q [$];
    int              n_cmp = 0, n_err = 0, wcnt = 0;
    int              id_cnt [N];

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .wclk(wclk), .sync_rstn(sync_rstn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_wfull(fifo_wfull),
        .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected word.
    always @(negedge wclk) begin
        if (sync_rstn && fifo_winc) begin
            check("winc_while_full", 32'(fifo_wfull), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h expected none", fifo_wdata);
            end else
                check("fifo_wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
            id_cnt[fifo_wdata[9:8]]++;
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pq[i].size() != 0;
            req_data[i*DW +: DW]  = (pq[i].size() != 0) ? pq[i][0][7:0] : 8'h00;
            req_last[i]           = (pq[i].size() != 0) ? pq[i][0][8] : 1'b0;
        end
    endtask

    task automatic step();
        @(negedge wclk);
        xfer = req_valid & req_ready;
        if (fifo_winc) wcnt++;
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++)
            if (xfer[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        drive();
        #1;
    endtask

    task automatic pkt(int r, int n, logic [7:0] base);
        for (int k = 0; k < n; k++) pq[r].push_back({k == n - 1, 8'(int'(base) + k)});
    endtask

    task automatic ex(int id, logic [7:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy || pending()) && k < 200) begin
            step();
            k++;
        end
        check({name, "_words_left"}, 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset(string name);
        sync_rstn = 1'b0;
        for (int i = 0; i < N; i++) pq[i].delete();
        drive();
        #1;
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_winc"}, 32'(fifo_winc), 0);
        check({name, "_ready"}, 32'(req_ready), 0);
        check({name, "_grant"}, 32'(grant_id), 0);
        step();
        step();
        sync_rstn = 1'b1;
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) id_cnt[i] = 0;
        drive();
        @(posedge wclk);
        #1;
        do_reset("rst0");

        // Single requester, three beats
        pkt(2, 3, 8'hA1);
        ex(2, 8'hA1); ex(2, 8'hA2); ex(2, 8'hA3);
        drive(); #1;
        step();
        check("t1_grant", 32'(grant_id), 2);
        check("t1_busy", 32'(busy), 1);
        repeat (3) step();
        check("t1_idle", 32'(busy), 0);
        drain("t1");

        // All four valid with single-beat packets from reset
        do_reset("rst2");
        for (int r = 0; r < N; r++) begin pkt(r, 1, 8'(8'h10 + r)); pkt(r, 1, 8'(8'h20 + r)); end
        for (int r = 0; r < N; r++) ex(r, 8'(8'h10 + r));
        for (int r = 0; r < N; r++) ex(r, 8'(8'h20 + r));
        drive(); #1;
        wcnt = 0;
        repeat (16) step();
        check("t2_winc_duty", 32'(wcnt), 8);
        drain("t2");

        // Burst splitting: req1 ten beats, req3 two beats
        for (int i = 0; i < N; i++) id_cnt[i] = 0;
        pkt(1, 10, 8'h40);
        pkt(3, 2, 8'h60);
        for (int k = 0; k < 4; k++) ex(1, 8'(8'h40 + k));
        ex(3, 8'h60); ex(3, 8'h61);
        for (int k = 4; k < 10; k++) ex(1, 8'(8'h40 + k));
        drive(); #1;
        drain("t3");
        check("t3_cnt_id1", 32'(id_cnt[1]), 10);
        check("t3_cnt_id3", 32'(id_cnt[3]), 2);

        // Stall on wfull after beat 2; beat count must hold
        pkt(0, 5, 8'h01);
        for (int k = 1; k <= 5; k++) ex(0, 8'(k));
        drive(); #1;
        repeat (3) step();
        fifo_wfull = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t4_stall_ready", 32'(req_ready), 0);
            check("t4_stall_winc", 32'(fifo_winc), 0);
            check("t4_stall_busy", 32'(busy), 1);
            step();
        end
        fifo_wfull = 1'b0;
        #1;
        check("t4_resume_winc", 32'(fifo_winc), 1);
        check("t4_resume_wdata", 32'(fifo_wdata), 32'h003);
        step();
        step();
        check("t4_release_at_4", 32'(busy), 0);
        drain("t4");

        // Valid drops without last while req 2 waits
        do_reset("rst5");
        pq[0].push_back({1'b0, 8'h77});
        pkt(2, 1, 8'h88);
        ex(0, 8'h77); ex(2, 8'h88);
        drive(); #1;
        step();
        check("t5_grant0", 32'(grant_id), 0);
        step();
        check("t5_busy_drop", 32'(busy), 1);
        step();
        check("t5_released", 32'(busy), 0);
        step();
        check("t5_grant2", 32'(grant_id), 2);
        check("t5_busy2", 32'(busy), 1);
        drain("t5");

        // Reset mid-burst of req 3, then req 0 and req 3 compete
        do_reset("rst6a");
        pkt(3, 3, 8'h31);
        ex(3, 8'h31);
        drive(); #1;
        step();
        check("t6_grant3", 32'(grant_id), 3);
        step();
        do_reset("rst6b");
        pkt(0, 1, 8'h05);
        pkt(3, 1, 8'h3F);
        ex(0, 8'h05); ex(3, 8'h3F);
        drive(); #1;
        step();
        check("t6_first_grant", 32'(grant_id), 0);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
